pmp_cfg_writer: RTL and testbench

PMP_CFG_WRITER -- requirements
Module: pmp_cfg_writer

---
 rtl/riscv_pkg.sv | 58 +++++
 rtl/pmp_cfg_lock_check.sv | 31 +++
 rtl/pmp_cfg_writer.sv | 193 +++++++++++++++++++
 tb/tb_pmp_cfg_writer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V PMP/DMP types: entry config layouts, domain encodings,
// request kinds for the config writer and the PMPCFG WARL legaliser.
package riscv;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_addr_mode_t;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } pmpcfg_access_t;

  // Bit layout matches the architectural pmpcfg byte: L, reserved, A, X, W, R.
  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmpcfg_access_t access_type;
  } pmpcfg_t;

  typedef enum logic [7:0] {
    DOMI = 8'h10,
    DOMA = 8'h21,
    DOMB = 8'h22,
    DOMC = 8'h23
  } dmp_domain_t;

  typedef struct packed {
    logic        locked;
    dmp_domain_t domain;
  } dmpcfg_t;

  typedef enum logic [1:0] {
    PMP_WR_CFG   = 2'd0,
    PMP_WR_ADDR  = 2'd1,
    PMP_WR_DMP   = 2'd2,
    PMP_WR_SWEEP = 2'd3
  } pmp_wr_kind_e;

  localparam int unsigned PMP_MAX_ENTRIES = 16;

  localparam dmpcfg_t DMPCFG_RESET = '{locked: 1'b0, domain: DOMI};

  // Reserved bits read as zero; the R=0,W=1 combination is illegal, so W drops.
  function automatic pmpcfg_t pmpcfg_legalize(input logic [7:0] raw);
    pmpcfg_t c;
    c          = pmpcfg_t'(raw);
    c.reserved = 2'b00;
    if (!c.access_type.r && c.access_type.w) c.access_type.w = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pmp_cfg_lock_check.sv
// Combinational writability of the cfg, addr and dmp registers of one entry,
// taking entry locks and the TOR lock of the following entry into account.
module pmp_cfg_lock_check
  import riscv::*;
#(
  parameter int unsigned NR_ENTRIES = 16
) (
  input  logic                              [3:0] idx_i,
  input  pmpcfg_t [PMP_MAX_ENTRIES-1:0]           pmpconf_i,
  input  dmpcfg_t [PMP_MAX_ENTRIES-1:0]           dmpconf_i,
  output logic                                    idx_valid_o,
  output logic                                    cfg_writable_o,
  output logic                                    addr_writable_o,
  output logic                                    dmp_writable_o
);

  logic [3:0] next_idx;
  logic       tor_guard;

  assign idx_valid_o = ({1'b0, idx_i} < 5'(NR_ENTRIES));
  assign next_idx    = idx_i + 4'd1;

  // A locked TOR entry also freezes the address below it (its range base).
  assign tor_guard = (idx_i != 4'd15) && pmpconf_i[next_idx].locked &&
                     (pmpconf_i[next_idx].addr_mode == TOR);

  assign cfg_writable_o  = idx_valid_o && !pmpconf_i[idx_i].locked;
  assign addr_writable_o = cfg_writable_o && !tor_guard;
  assign dmp_writable_o  = idx_valid_o && !dmpconf_i[idx_i].locked;

endmodule

// File: rtl/pmp_cfg_writer.sv
// Serialised writer for PMP cfg/addr and DMP domain registers, plus a
// domain-rename sweep that walks every implemented entry one per cycle.
module pmp_cfg_writer
  import riscv::*;
#(
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned PMP_LEN    = 54
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          req_valid_i,
  output logic                                          req_ready_o,
  input  logic                    [1:0]                 req_kind_i,
  input  logic                    [3:0]                 req_idx_i,
  input  logic                    [63:0]                req_wdata_i,
  output logic                                          rsp_valid_o,
  output logic                                          rsp_err_o,
  output logic                                          busy_o,
  output logic [PMP_MAX_ENTRIES-1:0][PMP_LEN-1:0]       conf_addr_o,
  output pmpcfg_t [PMP_MAX_ENTRIES-1:0]                 pmpconf_o,
  output dmpcfg_t [PMP_MAX_ENTRIES-1:0]                 dmpconf_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_RESP
  } state_e;

  localparam logic [3:0] LAST_IDX = (NR_ENTRIES == 0) ? 4'd0 : 4'(NR_ENTRIES - 1);

  state_e       state_q, state_d;
  logic         err_q, err_d;
  logic         skip_q, skip_d;
  logic [3:0]   cnt_q, cnt_d;
  dmp_domain_t  from_q, from_d;
  dmp_domain_t  to_q, to_d;

  pmpcfg_t [PMP_MAX_ENTRIES-1:0]              cfg_q;
  logic    [PMP_MAX_ENTRIES-1:0][PMP_LEN-1:0] addr_q;
  dmpcfg_t [PMP_MAX_ENTRIES-1:0]              dmp_q;

  logic [PMP_MAX_ENTRIES-1:0] cfg_we, addr_we, dmp_we, dom_we;

  pmp_wr_kind_e kind;
  logic         accept;
  logic         sweep_hit;
  logic         idx_valid, cfg_ok, addr_ok, dmp_ok;
  logic         unused_bits;

  assign kind        = pmp_wr_kind_e'(req_kind_i);
  assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  pmp_cfg_lock_check #(
    .NR_ENTRIES (NR_ENTRIES)
  ) u_lock_check (
    .idx_i           (req_idx_i),
    .pmpconf_i       (cfg_q),
    .dmpconf_i       (dmp_q),
    .idx_valid_o     (idx_valid),
    .cfg_writable_o  (cfg_ok),
    .addr_writable_o (addr_ok),
    .dmp_writable_o  (dmp_ok)
  );

  // A rename onto the same domain is a no-op, so it can never count as a skip.
  assign sweep_hit = (dmp_q[cnt_q].domain == from_q) && (from_q != to_q);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    from_d  = from_q;
    to_d    = to_q;
    cfg_we  = '0;
    addr_we = '0;
    dmp_we  = '0;
    dom_we  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          unique case (kind)
            PMP_WR_CFG: begin
              if (cfg_ok) cfg_we[req_idx_i] = 1'b1;
              else        err_d = 1'b1;
            end
            PMP_WR_ADDR: begin
              if (addr_ok) addr_we[req_idx_i] = 1'b1;
              else         err_d = 1'b1;
            end
            PMP_WR_DMP: begin
              if (dmp_ok) dmp_we[req_idx_i] = 1'b1;
              else        err_d = 1'b1;
            end
            PMP_WR_SWEEP: begin
              if (NR_ENTRIES == 0) begin
                err_d = 1'b1;
              end else begin
                state_d = ST_SWEEP;
                from_d  = dmp_domain_t'(req_wdata_i[7:0]);
                to_d    = dmp_domain_t'(req_wdata_i[15:8]);
                cnt_d   = 4'd0;
                skip_d  = 1'b0;
              end
            end
          endcase
        end
      end
      ST_SWEEP: begin
        if (sweep_hit) begin
          if (dmp_q[cnt_q].locked) skip_d = 1'b1;
          else                     dom_we[cnt_q] = 1'b1;
        end
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RESP;
          err_d   = skip_d;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      skip_q  <= 1'b0;
      cnt_q   <= 4'd0;
      from_q  <= DOMI;
      to_q    <= DOMI;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      from_q  <= from_d;
      to_q    <= to_d;
    end
  end

  for (genvar i = 0; i < PMP_MAX_ENTRIES; i++) begin : g_entry
    if (i < NR_ENTRIES) begin : g_impl
      pmpcfg_t            cfg_r;
      logic [PMP_LEN-1:0] addr_r;
      dmpcfg_t            dmp_r;

      // NOTE: this register file is reset, unlike a plain storage array, because
      // lock bits must come up clear and reset is their only clearing path.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cfg_r  <= '0;
          addr_r <= '0;
          dmp_r  <= DMPCFG_RESET;
        end else begin
          if (cfg_we[i])  cfg_r  <= pmpcfg_legalize(req_wdata_i[7:0]);
          if (addr_we[i]) addr_r <= req_wdata_i[PMP_LEN-1:0];
          if (dmp_we[i])       dmp_r        <= dmpcfg_t'(req_wdata_i[$bits(dmpcfg_t)-1:0]);
          else if (dom_we[i])  dmp_r.domain <= to_q;
        end
      end

      assign cfg_q[i]  = cfg_r;
      assign addr_q[i] = addr_r;
      assign dmp_q[i]  = dmp_r;
    end else begin : g_unimpl
      assign cfg_q[i]  = '0;
      assign addr_q[i] = '0;
      assign dmp_q[i]  = DMPCFG_RESET;
    end
  end

  assign unused_bits = ^{req_wdata_i, cfg_we, addr_we, dmp_we, dom_we, idx_valid};

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = (state_q == ST_RESP) && err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign conf_addr_o = addr_q;
  assign pmpconf_o   = cfg_q;
  assign dmpconf_o   = dmp_q;

endmodule

// File: tb/tb_pmp_cfg_writer.sv
// Randomised bench for pmp_cfg_writer against an array-based reference model,
// with directed cases for locking, WARL, out-of-range, sweeps and mid-sweep reset.
module tb_pmp_cfg_writer;
  import riscv::*;

  localparam int unsigned NR  = 8;
  localparam int unsigned LEN = 54;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0]  req_kind = 2'd0;
  logic [3:0]  req_idx = 4'd0;
  logic [63:0] req_wdata = 64'd0;
  logic rsp_valid, rsp_err, busy;
  logic    [15:0][LEN-1:0] conf_addr;
  pmpcfg_t [15:0]          pmpconf;
  dmpcfg_t [15:0]          dmpconf;

  pmp_cfg_writer #(.NR_ENTRIES(NR), .PMP_LEN(LEN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_kind_i  (req_kind),
    .req_idx_i   (req_idx),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .conf_addr_o (conf_addr),
    .pmpconf_o   (pmpconf),
    .dmpconf_o   (dmpconf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain per-entry arrays updated by the architectural rules.
  logic [7:0]     m_cfg  [16];
  logic [LEN-1:0] m_addr [16];
  logic           m_lock [16];
  logic [7:0]     m_dom  [16];

  logic [7:0] dom_pool [4];

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cfg[i]  = 8'h00;
      m_addr[i] = '0;
      m_lock[i] = 1'b0;
      m_dom[i]  = 8'(DOMI);
    end
  endfunction

  function automatic void model_apply(input logic [1:0] kind, input logic [3:0] idx,
                                      input logic [63:0] wd, output logic err, output int lat);
    logic [7:0] b;
    logic [7:0] from, to;
    err = 1'b0;
    lat = 1;
    case (kind)
      2'd0: begin
        if (idx >= NR || m_cfg[idx][7]) err = 1'b1;
        else begin
          b = wd[7:0] & 8'h9F;
          if (!b[0] && b[1]) b[1] = 1'b0;
          m_cfg[idx] = b;
        end
      end
      2'd1: begin
        if (idx >= NR || m_cfg[idx][7]) err = 1'b1;
        else if (idx < 15 && m_cfg[idx+1][7] && m_cfg[idx+1][4:3] == 2'd1) err = 1'b1;
        else m_addr[idx] = wd[LEN-1:0];
      end
      2'd2: begin
        if (idx >= NR || m_lock[idx]) err = 1'b1;
        else begin
          m_lock[idx] = wd[8];
          m_dom[idx]  = wd[7:0];
        end
      end
      default: begin
        from = wd[7:0];
        to   = wd[15:8];
        lat  = NR + 1;
        if (NR == 0) err = 1'b1;
        for (int i = 0; i < NR; i++) begin
          if (m_dom[i] == from && from != to) begin
            if (m_lock[i]) err = 1'b1;
            else           m_dom[i] = to;
          end
        end
      end
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    logic [7:0] c;
    logic [8:0] d;
    for (int i = 0; i < 16; i++) begin
      c = pmpconf[i];
      d = dmpconf[i];
      check($sformatf("%s_cfg%0d", tag, i), 64'(c), 64'(m_cfg[i]));
      check($sformatf("%s_addr%0d", tag, i), 64'(conf_addr[i]), 64'(m_addr[i]));
      check($sformatf("%s_dmp%0d", tag, i), 64'(d), 64'({m_lock[i], m_dom[i]}));
    end
  endtask

  task automatic do_req(input logic [1:0] kind, input logic [3:0] idx, input logic [63:0] wd);
    logic exp_err;
    int   exp_lat;
    int   cyc;
    model_apply(kind, idx, wd, exp_err, exp_lat);
    @(negedge clk);
    check("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_kind  = kind;
    req_idx   = idx;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    cyc = 1;
    while (!rsp_valid && cyc < 64) begin
      check("ready_busy", 64'(req_ready), 64'd0);
      check("busy", 64'(busy), 64'd1);
      @(negedge clk);
      cyc++;
    end
    check("rsp_seen", 64'(rsp_valid), 64'd1);
    check("latency", 64'(cyc), 64'(exp_lat));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("ready_resp", 64'(req_ready), 64'd0);
    check_outputs("rsp");
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp"}, 64'(rsp_valid), 64'd0);
    check({tag, "_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check_outputs(tag);
  endtask

  task automatic sweep_then_reset(input logic [63:0] wd);
    int seen_rsp;
    seen_rsp = 0;
    @(negedge clk);
    check("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_kind  = 2'd3;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      if (rsp_valid) seen_rsp++;
      @(negedge clk);
    end
    check("sweep_busy5", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_state("async_rst");
    @(negedge clk);
    if (rsp_valid) seen_rsp++;
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(req_ready), 64'd1);
    check("no_rsp_abort", 64'(seen_rsp), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("no_rsp_post", 64'(rsp_valid), 64'd0);
    end
  endtask

  function automatic logic [63:0] rand_wdata(input logic [1:0] kind);
    logic [63:0] w;
    w = {$urandom, $urandom};
    case (kind)
      2'd0: if ($urandom_range(0, 7) != 0) w[7] = 1'b0;
      2'd2: begin
        w[7:0] = dom_pool[$urandom_range(0, 3)];
        w[8]   = ($urandom_range(0, 9) == 0);
      end
      2'd3: begin
        w[7:0]  = dom_pool[$urandom_range(0, 3)];
        w[15:8] = dom_pool[$urandom_range(0, 3)];
      end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    logic [1:0] k;
    dom_pool[0] = 8'(DOMI);
    dom_pool[1] = 8'(DOMA);
    dom_pool[2] = 8'(DOMB);
    dom_pool[3] = 8'(DOMC);
    model_reset();

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Basic cfg write, checked against the literal value as well.
    do_req(2'd0, 4'd2, 64'h0B);
    c = pmpconf[2];
    check("cfg2_literal", 64'(c), 64'h0B);

    // Locked entry blocks its own address.
    do_req(2'd0, 4'd1, 64'h82);
    do_req(2'd1, 4'd1, 64'h1234);
    check("addr1_literal", 64'(conf_addr[1]), 64'd0);

    // Locked TOR above freezes the address below it only.
    do_req(2'd0, 4'd3, 64'h88);
    do_req(2'd1, 4'd2, 64'hABCD);
    do_req(2'd1, 4'd4, 64'hFFFF_0000_5555_AAAA);

    // Domain rename sweep with one locked match.
    do_req(2'd2, 4'd0, 64'(DOMA));
    do_req(2'd2, 4'd1, 64'(DOMB));
    do_req(2'd2, 4'd2, 64'(DOMA));
    do_req(2'd2, 4'd3, 64'h100 | 64'(DOMA));
    do_req(2'd3, 4'd0, (64'(DOMC) << 8) | 64'(DOMA));
    check("dom0_literal", 64'(dmpconf[0].domain), 64'(DOMC));
    check("dom3_literal", 64'(dmpconf[3].domain), 64'(DOMA));

    // WARL, out-of-range and identity sweep.
    do_req(2'd0, 4'd5, 64'h02);
    c = pmpconf[5];
    check("warl_literal", 64'(c), 64'h00);
    do_req(2'd0, 4'd15, 64'h1F);
    do_req(2'd1, 4'd15, 64'h77);
    do_req(2'd2, 4'd9, 64'(DOMB));
    do_req(2'd3, 4'd0, (64'(DOMB) << 8) | 64'(DOMB));

    sweep_then_reset((64'(DOMC) << 8) | 64'(DOMI));

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        sweep_then_reset(rand_wdata(2'd3));
      end else begin
        k = 2'($urandom_range(0, 3));
        do_req(k, 4'($urandom_range(0, 15)), rand_wdata(k));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
